// File: rtl/lsu_ctrl_pkg.sv
// Shared widths, fun-code bit positions and FSM state encoding for the load/store sequencer.
package lsu_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int LD_FUN_W = 5;
    localparam int ST_FUN_W = 3;

    // One-hot positions: ld_fun = {lhu,lbu,lw,lh,lb}, st_fun = {sw,sh,sb}
    localparam int LD_LB  = 0;
    localparam int LD_LH  = 1;
    localparam int LD_LW  = 2;
    localparam int LD_LBU = 3;
    localparam int LD_LHU = 4;
    localparam int ST_SB  = 0;
    localparam int ST_SH  = 1;
    localparam int ST_SW  = 2;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_WAIT   = 2'd1,
        LSU_ACCESS = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// EX request, mem datapath and WB result signals of lsu_ctrl; names follow the lsu_ctrl side.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic                ex_valid_i;
    logic                ex_ready_o;
    logic                ld_i;
    logic                st_i;
    logic [LD_FUN_W-1:0] ld_fun_i;
    logic [ST_FUN_W-1:0] st_fun_i;
    logic [XLEN-1:0]     addr_i;
    logic [XLEN-1:0]     wdata_i;
    logic [4:0]          rd_i;

    logic                mem_ld_o;
    logic                mem_st_o;
    logic [LD_FUN_W-1:0] mem_ld_fun_o;
    logic [ST_FUN_W-1:0] mem_st_fun_o;
    logic [XLEN-1:0]     mem_addr_o;
    logic [XLEN-1:0]     mem_wdata_o;
    logic [XLEN-1:0]     mem_rdata_i;

    logic                wb_valid_o;
    logic                wb_ready_i;
    logic                wb_we_o;
    logic [4:0]          wb_rd_o;
    logic [XLEN-1:0]     wb_data_o;
    logic                wb_exc_o;

    modport slave (
        input  ex_valid_i, ld_i, st_i, ld_fun_i, st_fun_i, addr_i, wdata_i, rd_i,
        input  mem_rdata_i, wb_ready_i,
        output ex_ready_o, mem_ld_o, mem_st_o, mem_ld_fun_o, mem_st_fun_o,
        output mem_addr_o, mem_wdata_o,
        output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_exc_o
    );

    modport master (
        output ex_valid_i, ld_i, st_i, ld_fun_i, st_fun_i, addr_i, wdata_i, rd_i,
        output mem_rdata_i, wb_ready_i,
        input  ex_ready_o, mem_ld_o, mem_st_o, mem_ld_fun_o, mem_st_fun_o,
        input  mem_addr_o, mem_wdata_o,
        input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, wb_exc_o
    );

endinterface

// File: rtl/lsu_align_chk.sv
// Combinational misalignment detector for halfword/word loads and stores (used only when
// LSU_MISALIGN_CHK_EN is defined).
module lsu_align_chk
    import lsu_ctrl_pkg::*;
(
    input  logic [LD_FUN_W-1:0] ld_fun_i,
    input  logic [ST_FUN_W-1:0] st_fun_i,
    input  logic [1:0]          addr_lo_i,
    output logic                misaligned_o
);

    logic is_half;
    logic is_word;

    assign is_half      = ld_fun_i[LD_LH] | ld_fun_i[LD_LHU] | st_fun_i[ST_SH];
    assign is_word      = ld_fun_i[LD_LW] | st_fun_i[ST_SW];
    assign misaligned_o = (is_half & addr_lo_i[0]) | (is_word & (addr_lo_i != 2'b00));

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: IDLE -> [WAIT] -> ACCESS -> RESP, one request in flight.
// Optional LSU_MISALIGN_CHK_EN turns misaligned halfword/word accesses into exceptions.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ld_q, ld_d;
    logic                st_q, st_d;
    logic [LD_FUN_W-1:0] ld_fun_q, ld_fun_d;
    logic [ST_FUN_W-1:0] st_fun_q, st_fun_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;
    logic                wb_we_q, wb_we_d;
    logic                wb_exc_q, wb_exc_d;
    logic                misaligned;
    logic                st_eff;

    // A simultaneous ld/st request is a load, so the store half is dropped at capture.
    assign st_eff = bus.st_i & ~bus.ld_i;

`ifdef LSU_MISALIGN_CHK_EN
    lsu_align_chk u_align_chk (
        .ld_fun_i     (bus.ld_fun_i & {LD_FUN_W{bus.ld_i}}),
        .st_fun_i     (bus.st_fun_i & {ST_FUN_W{st_eff}}),
        .addr_lo_i    (bus.addr_i[1:0]),
        .misaligned_o (misaligned)
    );
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_d      = ld_q;
        st_d      = st_q;
        ld_fun_d  = ld_fun_q;
        st_fun_d  = st_fun_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        wb_we_d   = wb_we_q;
        wb_exc_d  = wb_exc_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.ex_valid_i) begin
                    ld_d     = bus.ld_i;
                    st_d     = st_eff;
                    ld_fun_d = bus.ld_fun_i;
                    st_fun_d = bus.st_fun_i;
                    addr_d   = bus.addr_i;
                    wdata_d  = bus.wdata_i;
                    rd_d     = bus.rd_i;
                    wb_exc_d = misaligned;
                    if (misaligned) begin
                        wb_data_d = bus.addr_i;
                        wb_we_d   = 1'b0;
                        state_d   = LSU_RESP;
                    end else if (!bus.ld_i && !bus.st_i) begin
                        wb_data_d = bus.wdata_i;
                        wb_we_d   = (bus.rd_i != 5'd0);
                        state_d   = LSU_RESP;
                    end else begin
                        wb_we_d = bus.ld_i && (bus.rd_i != 5'd0);
                        cnt_d   = '0;
                        state_d = (MEM_LATENCY > 0) ? LSU_WAIT : LSU_ACCESS;
                    end
                end
            end
            LSU_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    state_d = LSU_ACCESS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_ACCESS: begin
                wb_data_d = ld_q ? bus.mem_rdata_i : '0;
                state_d   = LSU_RESP;
            end
            LSU_RESP: begin
                if (bus.wb_ready_i) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= LSU_IDLE;
            cnt_q     <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            ld_fun_q  <= '0;
            st_fun_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_exc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            ld_fun_q  <= ld_fun_d;
            st_fun_q  <= st_fun_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            wb_exc_q  <= wb_exc_d;
        end
    end

    // Strobes come from the state register alone, so async reset kills them immediately.
    assign bus.ex_ready_o   = (state_q == LSU_IDLE);
    assign bus.mem_ld_o     = (state_q == LSU_ACCESS) & ld_q;
    assign bus.mem_st_o     = (state_q == LSU_ACCESS) & st_q;
    assign bus.mem_ld_fun_o = ld_fun_q;
    assign bus.mem_st_fun_o = st_fun_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.wb_valid_o   = (state_q == LSU_RESP);
    assign bus.wb_we_o      = wb_we_q;
    assign bus.wb_rd_o      = rd_q;
    assign bus.wb_data_o    = wb_data_q;
    assign bus.wb_exc_o     = wb_exc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Runs two lsu_ctrl lanes (MEM_LATENCY=3 and 0) in lockstep against a small memory model and a
// queue of expected results.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int NL = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic        exc;
        logic [4:0]  rd;
        logic        mem_op;
        logic        is_store;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ld, st, wb_ready;
    logic [4:0]  ld_fun;
    logic [2:0]  st_fun;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;

    logic         ex_ready [NL];
    logic         wb_valid [NL];
    logic         wb_we    [NL];
    logic         wb_exc   [NL];
    logic         mem_ld   [NL];
    logic         mem_st   [NL];
    logic [4:0]   wb_rd    [NL];
    logic [31:0]  wb_data  [NL];
    logic [113:0] out_vec  [NL];

    logic [31:0] ref_mem [16];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(int lane);
        return (lane == 0) ? 3 : 0;
    endfunction

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h1020_3040 + 32'h0101_0101 * 32'(i);
    endfunction

    function automatic logic [31:0] fmt_load(logic [31:0] w, logic [1:0] a, logic [4:0] f);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (f[LD_LB])  return {{24{b[7]}}, b};
        if (f[LD_LBU]) return {24'd0, b};
        if (f[LD_LH])  return {{16{h[15]}}, h};
        if (f[LD_LHU]) return {16'd0, h};
        if (f[LD_LW])  return w;
        return 32'd0;
    endfunction

    function automatic logic [31:0] apply_store(logic [31:0] w, logic [1:0] a, logic [2:0] f,
                                                logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (f[ST_SB]) r[{a, 3'b000} +: 8] = d[7:0];
        if (f[ST_SH]) r[{a[1], 4'b0000} +: 16] = d[15:0];
        if (f[ST_SW]) r = d;
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            lsu_ctrl_if bus ();
            logic [31:0] mem [16];

            lsu_ctrl #(.MEM_LATENCY(gi == 0 ? 3 : 0), .CNT_W(4)) dut (
                .clk_i   (clk),
                .rst_n_i (rst_n),
                .bus     (bus.slave)
            );

            assign bus.ex_valid_i  = ex_valid;
            assign bus.ld_i        = ld;
            assign bus.st_i        = st;
            assign bus.ld_fun_i    = ld_fun;
            assign bus.st_fun_i    = st_fun;
            assign bus.addr_i      = addr;
            assign bus.wdata_i     = wdata;
            assign bus.rd_i        = rd;
            assign bus.wb_ready_i  = wb_ready;
            assign bus.mem_rdata_i = fmt_load(mem[bus.mem_addr_o[5:2]], bus.mem_addr_o[1:0],
                                              bus.mem_ld_fun_o);

            initial begin
                for (int i = 0; i < 16; i++) mem[i] = init_word(i);
            end
            always @(posedge clk) begin
                if (bus.mem_st_o)
                    mem[bus.mem_addr_o[5:2]] <= apply_store(mem[bus.mem_addr_o[5:2]],
                        bus.mem_addr_o[1:0], bus.mem_st_fun_o, bus.mem_wdata_o);
            end

            assign ex_ready[gi] = bus.ex_ready_o;
            assign wb_valid[gi] = bus.wb_valid_o;
            assign wb_we[gi]    = bus.wb_we_o;
            assign wb_exc[gi]   = bus.wb_exc_o;
            assign mem_ld[gi]   = bus.mem_ld_o;
            assign mem_st[gi]   = bus.mem_st_o;
            assign wb_rd[gi]    = bus.wb_rd_o;
            assign wb_data[gi]  = bus.wb_data_o;
            assign out_vec[gi]  = {bus.mem_ld_o, bus.mem_st_o, bus.mem_ld_fun_o, bus.mem_st_fun_o,
                                   bus.mem_addr_o, bus.mem_wdata_o, bus.wb_valid_o, bus.wb_we_o,
                                   bus.wb_rd_o, bus.wb_data_o, bus.wb_exc_o};
        end
    endgenerate

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    task automatic run_txn(input logic l, input logic s, input logic [4:0] lf,
                           input logic [2:0] sf, input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] r, input int hold);
        exp_t e;
        exp_t cur;
        logic misal;
        int   n;
        int   cyc;
        bit   done [NL];
        int   strobes [NL];

`ifdef LSU_MISALIGN_CHK_EN
        misal = (l && (((lf[LD_LH] || lf[LD_LHU]) && a[0]) || (lf[LD_LW] && a[1:0] != 2'b00))) ||
                (s && !l && ((sf[ST_SH] && a[0]) || (sf[ST_SW] && a[1:0] != 2'b00)));
`else
        misal = 1'b0;
`endif
        e = '0;
        e.rd = r;
        if (misal) begin
            e.data = a;
            e.exc  = 1'b1;
        end else if (l) begin
            e.data   = fmt_load(ref_mem[a[5:2]], a[1:0], lf);
            e.we     = (r != 5'd0);
            e.mem_op = 1'b1;
        end else if (s) begin
            ref_mem[a[5:2]] = apply_store(ref_mem[a[5:2]], a[1:0], sf, d);
            e.mem_op   = 1'b1;
            e.is_store = 1'b1;
        end else begin
            e.data = d;
            e.we   = (r != 5'd0);
        end
        exp_q.push_back(e);

        n = 0;
        while (!(ex_ready[0] && ex_ready[1]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 128'(n < 50), 128'(1));

        ex_valid = 1'b1; ld = l; st = s; ld_fun = lf; st_fun = sf;
        addr = a; wdata = d; rd = r;
        for (int i = 0; i < NL; i++) begin done[i] = 0; strobes[i] = 0; end
        cyc = 0;
        cur = exp_q[0];
        while (!(done[0] && done[1]) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) ex_valid = 1'b0;
            for (int i = 0; i < NL; i++) begin
                if (mem_ld[i] || mem_st[i]) begin
                    strobes[i]++;
                    chk($sformatf("strobe_cyc%0d", i), 128'(cyc), 128'(lat_of(i) + 1));
                    chk($sformatf("mem_st%0d", i), 128'(mem_st[i]), 128'(cur.is_store));
                end
                if (wb_valid[i] && !done[i]) begin
                    done[i] = 1;
                    chk($sformatf("lat%0d", i), 128'(cyc),
                        128'(cur.mem_op ? lat_of(i) + 2 : 1));
                    chk($sformatf("data%0d", i), 128'(wb_data[i]), 128'(cur.data));
                    chk($sformatf("we%0d", i), 128'(wb_we[i]), 128'(cur.we));
                    chk($sformatf("exc%0d", i), 128'(wb_exc[i]), 128'(cur.exc));
                    chk($sformatf("rd%0d", i), 128'(wb_rd[i]), 128'(cur.rd));
                end
            end
        end
        for (int i = 0; i < NL; i++) chk($sformatf("resp_seen%0d", i), 128'(done[i]), 128'(1));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NL; i++) begin
                chk($sformatf("hold_valid%0d", i), 128'(wb_valid[i]), 128'(1));
                chk($sformatf("hold_data%0d", i), 128'(wb_data[i]), 128'(cur.data));
                chk($sformatf("hold_ready%0d", i), 128'(ex_ready[i]), 128'(0));
            end
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("idle_after%0d", i), 128'({ex_ready[i], wb_valid[i]}), 128'(2'b10));
            chk($sformatf("strobes%0d", i), 128'(strobes[i]), 128'(cur.mem_op ? 1 : 0));
        end
        void'(exp_q.pop_front());
        $display("txn ld=%0b st=%0b addr=%08h exp_data=%08h we=%0b exc=%0b", l, s, a, cur.data,
                 cur.we, cur.exc);
    endtask

    task automatic reset_in_wait();
        while (!(ex_ready[0] && ex_ready[1])) begin @(posedge clk); #1; end
        ex_valid = 1'b1; ld = 1'b0; st = 1'b1; ld_fun = 5'd0; st_fun = 3'b100;
        addr = 32'h8000_0008; wdata = 32'hCAFE_F00D; rd = 5'd0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("rst_pre_st1", 128'(mem_st[1]), 128'(1));
        chk("rst_pre_st0", 128'({mem_st[0], ex_ready[0]}), 128'(0));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("rst_out%0d", i), 128'(out_vec[i]), 128'(0));
            chk($sformatf("rst_rdy%0d", i), 128'(ex_ready[i]), 128'(1));
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("txn reset during WAIT of sw addr=80000008 dropped");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ex_valid = 0; ld = 0; st = 0; ld_fun = 0; st_fun = 0;
        addr = 0; wdata = 0; rd = 0; wb_ready = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("reset_out%0d", i), 128'(out_vec[i]), 128'(0));
            chk($sformatf("reset_rdy%0d", i), 128'(ex_ready[i]), 128'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_0010, 32'h0,         5'd5, 0);
        run_txn(0, 1, 5'b00000, 3'b001, 32'h8000_0003, 32'h0000_00AB, 5'd0, 0);
        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_0000, 32'h0,         5'd1, 0);
        run_txn(1, 0, 5'b01000, 3'b000, 32'h8000_0003, 32'h0,         5'd2, 0);
        run_txn(1, 0, 5'b00001, 3'b000, 32'h8000_0003, 32'h0,         5'd2, 0);
        run_txn(1, 0, 5'b00010, 3'b000, 32'h8000_0012, 32'h0,         5'd4, 0);
        run_txn(1, 0, 5'b10000, 3'b000, 32'h8000_0012, 32'h0,         5'd4, 0);
        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_0014, 32'h0,         5'd6, 5);
        run_txn(0, 1, 5'b00000, 3'b010, 32'h8000_0006, 32'h5A5A_7788, 5'd0, 0);
        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_0004, 32'h0,         5'd8, 0);
        reset_in_wait();
        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_0008, 32'h0,         5'd9, 0);
        run_txn(1, 0, 5'b00010, 3'b000, 32'h8000_0001, 32'h0,         5'd3, 0);
        run_txn(0, 1, 5'b00000, 3'b100, 32'h8000_000E, 32'h1122_3344, 5'd0, 0);
        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_000C, 32'h0,         5'd10, 0);
        run_txn(0, 0, 5'b00000, 3'b000, 32'h0,         32'h0000_1234, 5'd0, 0);
        run_txn(0, 0, 5'b00000, 3'b000, 32'h0,         32'h0000_55AA, 5'd7, 2);
        run_txn(1, 1, 5'b00100, 3'b100, 32'h8000_0010, 32'h0BAD_0BAD, 5'd11, 0);
        run_txn(1, 0, 5'b00100, 3'b000, 32'h8000_0010, 32'h0,         5'd12, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
